video_overlay_ctrl: RTL

Sequencing and configuration controller for the LCD overlay stage in the OV5640→SDRAM→LCD480 path. Debounces the two user keys into single-cycle `windows` / `color` toggle pulses released only at frame start, and double-buffers three bounding boxes from the detector so the overlay never tears mid-frame. Generates the pixel coordinates (`active_x`, `active_y`) that the overlay compares against the boxes. Sits between the key inputs, the detection logic and the video output mux, all in the video clock domain.

---
 rtl/video_overlay_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/video_overlay_ctrl.sv
// Key debounce, frame-aligned toggle pulses, double-buffered boxes
// and pixel coordinate counters for the LCD overlay stage.
module video_overlay_ctrl #(
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        key_win_n,
  input  logic        key_color_n,
  input  logic        vsync,
  input  logic        de,
  input  logic [47:0] box_in,
  input  logic        box_wr,
  input  logic [1:0]  box_id,
  output logic        windows,
  output logic        color,
  output logic [47:0] loc_out1,
  output logic [47:0] loc_out2,
  output logic [47:0] loc_out3,
  output logic [11:0] active_x,
  output logic [11:0] active_y
);

  localparam logic [47:0] PARK = 48'hFFFF_FFFF_FFFF;

  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  stable_q, stable_d;
  logic [19:0] cnt_q [2];
  logic [19:0] cnt_d [2];
  logic [1:0]  press;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  pulse_q, pulse_d;
  logic        vsync_d_q;
  logic        de_d_q;
  logic        fs;
  logic        box_ok;
  logic [47:0] shadow_q [3];
  logic [47:0] shadow_d [3];
  logic [47:0] loc_q [3];
  logic [47:0] loc_d [3];
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;

  assign fs = vsync & ~vsync_d_q;
  assign box_ok = (box_in[47:36] <= box_in[35:24])
                & (box_in[23:12] <= box_in[11:0]);

  // Index 0 is the window key, index 1 the colour key.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cnt_d[k]    = cnt_q[k];
      stable_d[k] = stable_q[k];
      press[k]    = 1'b0;
      if (sync2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == DEBOUNCE_CNT - 20'd1) begin
        stable_d[k] = sync2_q[k];
        cnt_d[k]    = '0;
        press[k]    = stable_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 20'd1;
      end
    end
  end

  // A press landing on the fs edge survives into the next frame.
  always_comb begin
    pend_d  = fs ? press : (pend_q | press);
    pulse_d = fs ? pend_q : 2'b00;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shadow_d[i] = shadow_q[i];
      loc_d[i]    = fs ? shadow_q[i] : loc_q[i];
      if (box_wr && box_id == 2'(i)) begin
        shadow_d[i] = box_ok ? box_in : PARK;
      end
    end
  end

  always_comb begin
    x_d = 12'd0;
    y_d = y_q;
    if (de) begin
      x_d = (x_q == 12'hFFF) ? x_q : x_q + 12'd1;
    end
    if (fs) begin
      y_d = 12'd0;
    end else if (de_d_q && !de && y_q != 12'hFFF) begin
      y_d = y_q + 12'd1;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      stable_q  <= 2'b11;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      pend_q    <= 2'b00;
      pulse_q   <= 2'b00;
      vsync_d_q <= 1'b0;
      de_d_q    <= 1'b0;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      for (int i = 0; i < 3; i++) begin
        shadow_q[i] <= PARK;
        loc_q[i]    <= PARK;
      end
    end else begin
      sync1_q   <= {key_color_n, key_win_n};
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pulse_q   <= pulse_d;
      vsync_d_q <= vsync;
      de_d_q    <= de;
      x_q       <= x_d;
      y_q       <= y_d;
      shadow_q  <= shadow_d;
      loc_q     <= loc_d;
    end
  end

  assign windows  = pulse_q[0];
  assign color    = pulse_q[1];
  assign loc_out1 = loc_q[0];
  assign loc_out2 = loc_q[1];
  assign loc_out3 = loc_q[2];
  assign active_x = x_q;
  assign active_y = y_q;

endmodule
